// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl
// Truth-table sequencer for a 2-input logic gate under test. On start it
// walks the gate inputs through 00, 01, 10, 11. Each vector is held for
// HOLD_CYCLES settle cycles and then sampled for one cycle. The sampled gate
// output is compared with the selected expected function. The block reports a
// per-vector mismatch map, a failed-vector count, and pass/done flags.
module gate_sweep_ctrl #(
   parameter int HOLD_CYCLES = 10     // settle cycles per vector, 1..255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] func,
   output logic       a,
   output logic       b,
   input  logic       c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] mismatch_map,
   output logic [2:0] err_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Function codes for the expected gate behaviour. Codes 6 and 7 are reserved.
   localparam logic [2:0] FN_AND  = 3'd0;
   localparam logic [2:0] FN_OR   = 3'd1;
   localparam logic [2:0] FN_NAND = 3'd2;
   localparam logic [2:0] FN_NOR  = 3'd3;
   localparam logic [2:0] FN_XOR  = 3'd4;
   localparam logic [2:0] FN_XNOR = 3'd5;

   // The last DRIVE cycle has hold count HOLD_CYCLES-1; SAMPLE follows it.
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   // Returns the expected gate output for vector v = {a,b} under function f.
   function automatic logic expected_out(input logic [2:0] f, input logic [1:0] v);
      logic x;
      logic y;
      x = v[1];
      y = v[0];
      case (f)
         FN_AND:  expected_out = x & y;
         FN_OR:   expected_out = x | y;
         FN_NAND: expected_out = ~(x & y);
         FN_NOR:  expected_out = ~(x | y);
         FN_XOR:  expected_out = x ^ y;
         FN_XNOR: expected_out = ~(x ^ y);
         default: expected_out = 1'b0;
      endcase
   endfunction

   state_t      state_q,  state_d;
   logic [1:0]  vec_q,    vec_d;
   logic [7:0]  hold_q,   hold_d;
   logic [2:0]  func_q,   func_d;
   logic        a_q,      a_d;
   logic        b_q,      b_d;
   logic        busy_q,   busy_d;
   logic        done_q,   done_d;
   logic        pass_q,   pass_d;
   logic [3:0]  map_q,    map_d;
   logic [2:0]  err_q,    err_d;

   logic        exp_c;
   logic        func_legal;
   logic        vec_miss;

   // The expected value follows the latched function, so later func changes are ignored.
   assign exp_c      = expected_out(func_q, vec_q);
   assign func_legal = (func <= FN_XNOR);
   assign vec_miss   = (c != exp_c);

   // State register and registered outputs; reset returns everything to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         vec_q   <= 2'd0;
         hold_q  <= 8'd0;
         func_q  <= 3'd0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         map_q   <= 4'd0;
         err_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         hold_q  <= hold_d;
         func_q  <= func_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         map_q   <= map_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic and next values of the registered outputs.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      hold_d  = hold_q;
      func_d  = func_q;
      a_d     = a_q;
      b_d     = b_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      map_d   = map_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            a_d    = 1'b0;
            b_d    = 1'b0;
            busy_d = 1'b0;
            if (start) begin
               func_d = func;
               if (func_legal) begin
                  // Results from the previous run are cleared at acceptance.
                  map_d   = 4'd0;
                  err_d   = 3'd0;
                  pass_d  = 1'b0;
                  vec_d   = 2'd0;
                  hold_d  = 8'd0;
                  a_d     = 1'b0;
                  b_d     = 1'b0;
                  busy_d  = 1'b1;
                  state_d = ST_DRIVE;
               end else begin
                  // A reserved function cannot be checked, so every vector is reported failed.
                  map_d   = 4'hF;
                  err_d   = 3'd4;
                  pass_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end

         ST_DRIVE: begin
            hold_d = hold_q + 8'd1;
            if (hold_q == HOLD_LAST) begin
               state_d = ST_SAMPLE;
            end
         end

         ST_SAMPLE: begin
            if (vec_miss) begin
               map_d[vec_q] = 1'b1;
               err_d        = err_q + 3'd1;
            end
            if (vec_q == 2'd3) begin
               // pass uses the count that already includes this final sample.
               pass_d  = (err_d == 3'd0);
               done_d  = 1'b1;
               busy_d  = 1'b0;
               a_d     = 1'b0;
               b_d     = 1'b0;
               state_d = ST_DONE;
            end else begin
               vec_d   = vec_q + 2'd1;
               hold_d  = 8'd0;
               a_d     = vec_d[1];
               b_d     = vec_d[0];
               state_d = ST_DRIVE;
            end
         end

         ST_DONE: begin
            // A start request during DONE is deliberately ignored.
            a_d     = 1'b0;
            b_d     = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign a            = a_q;
   assign b            = b_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign mismatch_map = map_q;
   assign err_cnt      = err_q;

endmodule
